// File: rtl/mem_stage_sb.sv
// mem_stage_sb: MEM stage with byte-lane load/store unit, in-order store buffer and req/gnt/rvalid memory port
module mem_stage_sb #(
  parameter int ADDR_W = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ALUres_MEM,
  input  logic [31:0]       MemWd,
  input  logic [31:0]       ExtImm_WB,
  input  logic [31:0]       ALUres_WB,
  input  logic [31:0]       MemRd_WB,
  input  logic [1:0]        MemWd_Fwd_ctr,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  output logic [31:0]       MemRd,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [2:0] {IDLE, DRAIN, LD_REQ, LD_WAIT, LD_DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-3:0] sb_addr [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [3:0] sb_be [SB_DEPTH];
  logic [PW-1:0] head, tail, midx;
  logic [CW-1:0] count;
  logic [ADDR_W-3:0] waddr;
  logic [31:0] cap, fwd, st_data, word, sft;
  logic [3:0] lane_be;
  logic [4:0] shamt;
  logic match, hit, full, ld_port, drain, push, pop;
  always_comb begin
    waddr = ALUres_MEM[ADDR_W-1:2];
    fwd = MemWd_Fwd_ctr == 2'd0 ? MemWd : MemWd_Fwd_ctr == 2'd1 ? ExtImm_WB :
          MemWd_Fwd_ctr == 2'd2 ? ALUres_WB : MemRd_WB;
    lane_be = MemSize == 2'd0 ? 4'b0001 << ALUres_MEM[1:0] :
              MemSize == 2'd1 ? (ALUres_MEM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_data = MemSize == 2'd0 ? {4{fwd[7:0]}} : MemSize == 2'd1 ? {2{fwd[15:0]}} : fwd;
  end
  always_comb begin
    match = 1'b0;
    midx = head;
    for (int i = 0; i < SB_DEPTH; i++)
      if (CW'(i) < count && sb_addr[PW'(head + PW'(i))] == waddr) begin
        match = 1'b1;
        midx = PW'(head + PW'(i));
      end
  end
  always_comb begin
    hit = match && (sb_be[midx] & lane_be) == lane_be;
    full = count == CW'(SB_DEPTH);
    ld_port = MemRead && !hit;
    word = state == LD_DONE ? cap : sb_data[midx];
    shamt = MemSize == 2'd0 ? {ALUres_MEM[1:0], 3'b000} :
            MemSize == 2'd1 ? {ALUres_MEM[1], 4'b0000} : 5'd0;
    sft = word >> shamt;
    MemRd = !MemRead ? 32'd0 :
            MemSize == 2'd0 ? {{24{MemSigned & sft[7]}}, sft[7:0]} :
            MemSize == 2'd1 ? {{16{MemSigned & sft[15]}}, sft[15:0]} : sft;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      cap <= '0;
    end else begin
      state <= state_nx;
      head <= pop ? head + 1'b1 : head;
      tail <= push ? tail + 1'b1 : tail;
      count <= count + CW'(push) - CW'(pop);
      if (state == LD_WAIT && mem_rvalid) cap <= mem_rdata;
    end
  end
  always_ff @(posedge clk)
    if (push) begin
      sb_addr[tail] <= waddr;
      sb_data[tail] <= st_data;
      sb_be[tail] <= lane_be;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !ld_port ? IDLE : match ? DRAIN : LD_REQ;
      DRAIN:   state_nx = count == '0 ? LD_REQ : DRAIN;
      LD_REQ:  state_nx = mem_gnt ? LD_WAIT : LD_REQ;
      LD_WAIT: state_nx = mem_rvalid ? LD_DONE : LD_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    drain = count != '0 && (state == DRAIN || (state == IDLE && !ld_port));
    mem_stall = state == DRAIN || state == LD_REQ || state == LD_WAIT ||
                (state == IDLE && (ld_port || (MemWrite && full)));
    mem_req = drain || state == LD_REQ;
    mem_we = drain;
    mem_addr = {drain ? sb_addr[head] : waddr, 2'b00};
    mem_wdata = drain ? sb_data[head] : 32'd0;
    mem_be = drain ? sb_be[head] : 4'b1111;
    push = MemWrite && !mem_stall;
    pop = drain && mem_gnt;
  end
endmodule

// File: tb/tb_mem_stage_sb.sv
// tb_mem_stage_sb: directed self-checking bench for mem_stage_sb
module tb_mem_stage_sb;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] ALUres_MEM, MemWd, ExtImm_WB, ALUres_WB, MemRd_WB, MemRd, mem_addr, mem_wdata, mem_rdata;
  logic [1:0] MemWd_Fwd_ctr, MemSize;
  logic MemRead, MemWrite, MemSigned, mem_stall, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0] mem_be;
  int vecs = 0;
  int errs = 0;
  int stalls;
  always #5 clk = ~clk;
  mem_stage_sb dut (
    .clk(clk), .rst(rst), .ALUres_MEM(ALUres_MEM), .MemWd(MemWd), .ExtImm_WB(ExtImm_WB),
    .ALUres_WB(ALUres_WB), .MemRd_WB(MemRd_WB), .MemWd_Fwd_ctr(MemWd_Fwd_ctr),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
    .MemRd(MemRd), .mem_stall(mem_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    ALUres_MEM = '0; MemWd = '0; ExtImm_WB = '0; ALUres_WB = '0; MemRd_WB = '0;
    MemWd_Fwd_ctr = 2'd0; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'd2; MemSigned = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_memrd", MemRd, 0);
    // sw 0xDEADBEEF @0x100 then lw hit
    @(negedge clk);
    rst = 1'b0; MemWrite = 1'b1; ALUres_MEM = 32'h100; MemWd = 32'hDEADBEEF; MemSize = 2'd2;
    #1;
    chk("sw_stall", mem_stall, 0);
    chk("sw_req_empty", mem_req, 0);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    chk("lw_hit_data", MemRd, 32'hDEADBEEF);
    chk("lw_hit_stall", mem_stall, 0);
    chk("lw_hit_no_read", mem_req & ~mem_we, 0);
    // sb 0x80 @0x103; head drain is presented but never granted
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; MemSize = 2'd0; ALUres_MEM = 32'h103; MemWd = 32'h80;
    #1;
    chk("sb_stall", mem_stall, 0);
    chk("drain0_req", mem_req, 1);
    chk("drain0_we", mem_we, 1);
    chk("drain0_addr", mem_addr, 32'h100);
    chk("drain0_be", mem_be, 4'b1111);
    chk("drain0_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1; MemSigned = 1'b1;
    #1;
    chk("lb_hit", MemRd, 32'hFFFFFF80);
    chk("lb_hit_stall", mem_stall, 0);
    @(negedge clk);
    MemSigned = 1'b0;
    #1;
    chk("lbu_hit", MemRd, 32'h00000080);
    // lh @0x102: partial hit -> drain then read
    @(negedge clk);
    MemSize = 2'd1; MemSigned = 1'b1; ALUres_MEM = 32'h102;
    #1;
    chk("lh_part_stall", mem_stall, 1);
    chk("lh_part_req", mem_req, 0);
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("dr1_addr", mem_addr, 32'h100);
    chk("dr1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("dr1_be", mem_be, 4'b1111);
    chk("dr1_stall", mem_stall, 1);
    @(negedge clk);
    #1;
    chk("dr2_we", mem_we, 1);
    chk("dr2_be", mem_be, 4'b1000);
    chk("dr2_wdata", mem_wdata, 32'h80808080);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("dr_empty_req", mem_req, 0);
    chk("dr_empty_stall", mem_stall, 1);
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("lh_rd_req", mem_req, 1);
    chk("lh_rd_we", mem_we, 0);
    chk("lh_rd_addr", mem_addr, 32'h100);
    chk("lh_rd_be", mem_be, 4'b1111);
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80ADBEEF;
    #1;
    chk("lh_wait_stall", mem_stall, 1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("lh_done_stall", mem_stall, 0);
    chk("lh_done_data", MemRd, 32'hFFFF80AD);
    // lw miss @0x200: gnt on 2nd request cycle, rvalid 3 cycles after gnt
    MemSize = 2'd2; MemSigned = 1'b0; ALUres_MEM = 32'h200;
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_gnt = (c == 2); mem_rvalid = (c == 5); mem_rdata = 32'hCAFEF00D;
      #1;
      if (!mem_stall) break;
      stalls++;
    end
    chk("miss_stall_cycles", stalls, 6);
    chk("miss_data", MemRd, 32'hCAFEF00D);
    // forwarded store data: ctr=2 selects ALUres_WB
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; MemRead = 1'b0; MemWrite = 1'b1;
    MemWd_Fwd_ctr = 2'd2; ALUres_WB = 32'h1234; MemWd = 32'hFFFF0000; ALUres_MEM = 32'h300;
    #1;
    chk("fwd_st_stall", mem_stall, 0);
    @(negedge clk);
    MemWrite = 1'b0; MemWd_Fwd_ctr = 2'd0; mem_gnt = 1'b1;
    #1;
    chk("fwd_addr", mem_addr, 32'h300);
    chk("fwd_wdata", mem_wdata, 32'h1234);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("fwd_sb_empty", mem_req, 0);
    // SB_DEPTH+1 stores with no grant
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MemWrite = 1'b1; ALUres_MEM = 32'h400 + 4 * i; MemWd = i + 1;
      #1;
      chk($sformatf("fill%0d_stall", i), mem_stall, 0);
    end
    @(negedge clk);
    ALUres_MEM = 32'h410; MemWd = 32'd5;
    #1;
    chk("full_stall", mem_stall, 1);
    @(negedge clk);
    #1;
    chk("full_stall_hold", mem_stall, 1);
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("full_pop_stall", mem_stall, 1);
    chk("order0_addr", mem_addr, 32'h400);
    chk("order0_wdata", mem_wdata, 32'd1);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("full_release", mem_stall, 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      MemWrite = 1'b0; mem_gnt = 1'b1;
      #1;
      chk($sformatf("order%0d_addr", k), mem_addr, 32'h400 + 4 * k);
      chk($sformatf("order%0d_wdata", k), mem_wdata, k + 1);
    end
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("order_empty", mem_req, 0);
    // reset during LD_WAIT, stray rvalid afterwards
    @(negedge clk);
    MemWrite = 1'b1; ALUres_MEM = 32'h500; MemWd = 32'h55;
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1; ALUres_MEM = 32'h600;
    #1;
    chk("bypass_stall", mem_stall, 1);
    chk("bypass_drain_withdrawn", mem_req, 0);
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("bypass_rd_we", mem_we, 0);
    chk("bypass_rd_addr", mem_addr, 32'h600);
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    #1;
    chk("ldwait_stall", mem_stall, 1);
    @(negedge clk);
    rst = 1'b0; MemRead = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("post_rst_stall", mem_stall, 0);
    chk("post_rst_memrd", MemRd, 0);
    chk("post_rst_sb_empty", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1'b0; MemRead = 1'b1; ALUres_MEM = 32'h500;
    #1;
    chk("discarded_store_miss", mem_stall, 1);
    @(negedge clk);
    rst = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
